temperature_response_controller: RTL and testbench
==================================================

TEMPERATURE_RESPONSE_CONTROLLER -- requirements
Module: temperature_response_controller

Interface
REQ-001 Parameter CONFIRM_COUNT, default 3, number of consecutive valid samples needed to confirm any condition change; legal range 1..15.
REQ-002 Parameter EVENT_W, default 8, width of the abnormal-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 sampleValid  input  1  one-cycle strobe; the abnormality flags are sampled only in cycles where it is high.
REQ-006 lowTempAbnormality  input  1  low-temperature flag from the abnormality detector stage.
REQ-007 highTempAbnormality  input  1  high-temperature flag from the abnormality detector stage.
REQ-008 clearFault  input  1  level; returns FAULT to NORMAL.
REQ-009 heaterOn  output  1  heater drive, registered.
REQ-010 coolerOn  output  1  cooler drive, registered.
REQ-011 alarm  output  1  fault indication, registered.
REQ-012 state  output  2  current FSM state: 00 NORMAL, 01 HEATING, 10 COOLING, 11 FAULT.
REQ-013 abnormalEventCount  output  EVENT_W  count of confirmed entries into HEATING, COOLING or FAULT; saturates at all-ones.

Function
REQ-014 Sample classification on each valid sample: LOW = low&!high; HIGH = high&!low; BOTH = low&high; OK = neither.
REQ-015 A 4-bit confirm counter tracks the candidate class; it increments on each valid sample matching the candidate, and resets to 1 with a new candidate on a mismatching valid sample.
REQ-016 Counter holds its value and candidate in cycles with sampleValid low; gaps do not break a run.
REQ-017 A transition fires on the valid sample that brings the counter to CONFIRM_COUNT; the counter then clears to 0.
REQ-018 NORMAL: confirmed LOW -> HEATING; confirmed HIGH -> COOLING; confirmed BOTH -> FAULT; OK -> stay.
REQ-019 HEATING: confirmed OK -> NORMAL; confirmed HIGH -> NORMAL (never directly to COOLING); confirmed BOTH -> FAULT; LOW -> stay.
REQ-020 COOLING: symmetric to HEATING; confirmed LOW -> NORMAL; confirmed BOTH -> FAULT.
REQ-021 FAULT: stays until clearFault is high in a cycle; then -> NORMAL with confirm counter cleared; flag inputs are ignored while in FAULT.
REQ-022 Outputs are a registered decode of the next state, so they change in the same cycle as state: heaterOn=1 only in HEATING, coolerOn=1 only in COOLING, alarm=1 only in FAULT.
REQ-023 heaterOn and coolerOn are never both 1 in any cycle.
REQ-024 Latency: from the first of CONFIRM_COUNT qualifying valid samples at cycle t (consecutive valid samples), state and outputs update at the edge ending the cycle of the last qualifying sample.
REQ-025 abnormalEventCount increments by 1 on each entry into HEATING, COOLING or FAULT; returns to NORMAL do not count; holds at 2^EVENT_W-1.
REQ-026 clearFault while not in FAULT has no effect.

Reset
REQ-027 rst low at a rising edge: state=NORMAL, heaterOn=coolerOn=alarm=0, confirm counter=0, candidate=OK, abnormalEventCount=0.
REQ-028 Reset has priority over all inputs, including sampleValid and clearFault in the same cycle, and aborts any partial confirmation run.

Verification
REQ-029 CONFIRM_COUNT=3; low=1 on 3 consecutive valid samples -> state=01, heaterOn=1 after 3rd sample edge, abnormalEventCount=1.
REQ-030 low=1 on 2 valid samples, then OK sample, then low=1 on 2 samples -> state stays 00, heaterOn=0.
REQ-031 In HEATING, high=1 on 3 valid samples -> state=00, heaterOn=coolerOn=0; 3 further high samples -> state=10, coolerOn=1, count=2.
REQ-032 low=high=1 on 3 valid samples with sampleValid gaps of 5 idle cycles between them -> state=11, alarm=1; flags toggled for 10 samples -> stays 11; clearFault=1 for 1 cycle -> state=00, alarm=0.
REQ-033 EVENT_W=2; force 5 confirmed entries -> abnormalEventCount=3 and holds.
REQ-034 rst=0 during a partial run (2 of 3 LOW samples) -> all outputs 0; next single LOW sample after reset does not change state.

Source files
------------

// File: rtl/temperature_response_controller.sv
// ============================================================================
// Module   : temperature_response_controller
// Brief    : Debounced heater/cooler/fault controller driven by sampled
//            low/high temperature abnormality flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module temperature_response_controller #(
    parameter int CONFIRM_COUNT = 3,
    parameter int EVENT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sampleValid,
    input  logic               lowTempAbnormality,
    input  logic               highTempAbnormality,
    input  logic               clearFault,
    output logic               heaterOn,
    output logic               coolerOn,
    output logic               alarm,
    output logic [1:0]         state,
    output logic [EVENT_W-1:0] abnormalEventCount
);

    typedef enum logic [1:0] {
        S_NORMAL  = 2'b00,
        S_HEATING = 2'b01,
        S_COOLING = 2'b10,
        S_FAULT   = 2'b11
    } state_t;

    // Sample class is simply {high, low}.
    localparam logic [1:0] c_CLS_OK   = 2'b00;
    localparam logic [1:0] c_CLS_LOW  = 2'b01;
    localparam logic [1:0] c_CLS_HIGH = 2'b10;
    localparam logic [1:0] c_CLS_BOTH = 2'b11;
    localparam logic [3:0] c_CONFIRM  = 4'(CONFIRM_COUNT);

    state_t             r_state;
    logic [1:0]         r_cand;
    logic [3:0]         r_cnt;
    logic               r_heater;
    logic               r_cooler;
    logic               r_alarm;
    logic [EVENT_W-1:0] r_evtCnt;

    logic [1:0] w_cls;
    logic [3:0] w_runLen;
    logic       w_confirm;
    state_t     w_nextState;
    logic       w_abnEntry;

    always_comb begin
        w_cls       = {highTempAbnormality, lowTempAbnormality};
        w_runLen    = (w_cls == r_cand) ? (r_cnt + 4'd1) : 4'd1;
        w_confirm   = sampleValid && (r_state != S_FAULT) && (w_runLen == c_CONFIRM);
        w_nextState = r_state;
        case (r_state)
            S_NORMAL: begin
                if (w_confirm) begin
                    case (w_cls)
                        c_CLS_LOW:  w_nextState = S_HEATING;
                        c_CLS_HIGH: w_nextState = S_COOLING;
                        c_CLS_BOTH: w_nextState = S_FAULT;
                        default:    w_nextState = S_NORMAL;
                    endcase
                end
            end
            S_HEATING: begin
                // An opposite-side excursion returns to NORMAL first, never crosses over.
                if (w_confirm) begin
                    case (w_cls)
                        c_CLS_LOW:  w_nextState = S_HEATING;
                        c_CLS_BOTH: w_nextState = S_FAULT;
                        default:    w_nextState = S_NORMAL;
                    endcase
                end
            end
            S_COOLING: begin
                if (w_confirm) begin
                    case (w_cls)
                        c_CLS_HIGH: w_nextState = S_COOLING;
                        c_CLS_BOTH: w_nextState = S_FAULT;
                        default:    w_nextState = S_NORMAL;
                    endcase
                end
            end
            default: begin
                if (clearFault) begin
                    w_nextState = S_NORMAL;
                end
            end
        endcase
        w_abnEntry = (w_nextState != r_state) && (w_nextState != S_NORMAL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_NORMAL;
            r_cand   <= c_CLS_OK;
            r_cnt    <= 4'd0;
            r_heater <= 1'b0;
            r_cooler <= 1'b0;
            r_alarm  <= 1'b0;
            r_evtCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_heater <= (w_nextState == S_HEATING);
            r_cooler <= (w_nextState == S_COOLING);
            r_alarm  <= (w_nextState == S_FAULT);
            if (w_abnEntry && (r_evtCnt != '1)) begin
                r_evtCnt <= r_evtCnt + EVENT_W'(1);
            end
            // Flags are ignored in FAULT; leaving it starts a fresh run.
            if (r_state == S_FAULT) begin
                if (clearFault) begin
                    r_cnt  <= 4'd0;
                    r_cand <= c_CLS_OK;
                end
            end else if (sampleValid) begin
                r_cand <= w_cls;
                r_cnt  <= w_confirm ? 4'd0 : w_runLen;
            end
        end
    end

    assign heaterOn           = r_heater;
    assign coolerOn           = r_cooler;
    assign alarm              = r_alarm;
    assign state              = r_state;
    assign abnormalEventCount = r_evtCnt;

endmodule

`default_nettype wire

// File: tb/tb_temperature_response_controller.sv
// ============================================================================
// Module   : tb_temperature_response_controller
// Brief    : Self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_temperature_response_controller;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sampleValid;
    logic       lowTempAbnormality;
    logic       highTempAbnormality;
    logic       clearFault;
    logic       heaterOn, coolerOn, alarm;
    logic [1:0] state;
    logic [7:0] abnormalEventCount;
    logic       sHeaterOn, sCoolerOn, sAlarm;
    logic [1:0] sState;
    logic [1:0] sEventCount;

    int tests = 0;
    int fails = 0;

    temperature_response_controller #(.CONFIRM_COUNT(N), .EVENT_W(8)) dut (
        .clk(clk), .rst(rst), .sampleValid(sampleValid),
        .lowTempAbnormality(lowTempAbnormality), .highTempAbnormality(highTempAbnormality),
        .clearFault(clearFault), .heaterOn(heaterOn), .coolerOn(coolerOn),
        .alarm(alarm), .state(state), .abnormalEventCount(abnormalEventCount)
    );

    temperature_response_controller #(.CONFIRM_COUNT(N), .EVENT_W(2)) dutSat (
        .clk(clk), .rst(rst), .sampleValid(sampleValid),
        .lowTempAbnormality(lowTempAbnormality), .highTempAbnormality(highTempAbnormality),
        .clearFault(clearFault), .heaterOn(sHeaterOn), .coolerOn(sCoolerOn),
        .alarm(sAlarm), .state(sState), .abnormalEventCount(sEventCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: remembers the last N valid classes since the last
    // confirmation; a condition is confirmed when N of them agree.
    int mState  = 0;
    int mEvents = 0;
    int q[$];
    bit checkEn = 1'b0;

    function automatic int nextOf(input int st, input int cls);
        // cls: 0 OK, 1 LOW, 2 HIGH, 3 BOTH ; st: 0 N, 1 H, 2 C, 3 F
        if (cls == 3) return 3;
        if (st == 0) return cls;
        if (st == 1) return (cls == 1) ? 1 : 0;
        return (cls == 2) ? 2 : 0;
    endfunction

    always @(posedge clk) begin
        int cls;
        int ns;
        bit same;
        if (!rst) begin
            mState  = 0;
            mEvents = 0;
            q.delete();
        end else if (mState == 3) begin
            if (clearFault) begin
                mState = 0;
                q.delete();
            end
        end else if (sampleValid) begin
            cls = (highTempAbnormality ? 2 : 0) + (lowTempAbnormality ? 1 : 0);
            q.push_back(cls);
            if (q.size() > N) void'(q.pop_front());
            same = (q.size() == N);
            foreach (q[i]) if (q[i] != cls) same = 1'b0;
            if (same) begin
                ns = nextOf(mState, cls);
                if (ns != 0 && ns != mState) mEvents++;
                mState = ns;
                q.delete();
            end
        end
        checkEn = 1'b1;
    end

    always @(negedge clk) begin
        if (checkEn) begin
            chk("state", 32'(state), 32'(mState));
            chk("heaterOn", 32'(heaterOn), 32'(mState == 1));
            chk("coolerOn", 32'(coolerOn), 32'(mState == 2));
            chk("alarm", 32'(alarm), 32'(mState == 3));
            chk("eventCount", 32'(abnormalEventCount), 32'((mEvents > 255) ? 255 : mEvents));
            chk("satEventCount", 32'(sEventCount), 32'((mEvents > 3) ? 3 : mEvents));
            chk("satState", 32'(sState), 32'(mState));
            chk("heaterCoolerExclusive", 32'(heaterOn & coolerOn), 32'd0);
        end
    end

    task automatic drive(input logic v, input logic lo, input logic hi, input logic cf);
        sampleValid         = v;
        lowTempAbnormality  = lo;
        highTempAbnormality = hi;
        clearFault          = cf;
        @(negedge clk);
    endtask

    task automatic rep(input int n, input logic lo, input logic hi);
        for (int i = 0; i < n; i++) drive(1'b1, lo, hi, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        sampleValid = 1'b0; lowTempAbnormality = 1'b0;
        highTempAbnormality = 1'b0; clearFault = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset state", 32'(state), 32'd0);
        chk("reset outputs", 32'({heaterOn, coolerOn, alarm}), 32'd0);
        chk("reset count", 32'(abnormalEventCount), 32'd0);
        rst = 1'b1;

        // Heating after three LOW samples, not before.
        rep(2, 1'b1, 1'b0);
        chk("heat latency", 32'(state), 32'd0);
        rep(1, 1'b1, 1'b0);
        chk("heat state", 32'(state), 32'd1);
        chk("heat heaterOn", 32'(heaterOn), 32'd1);
        chk("heat count", 32'(abnormalEventCount), 32'd1);

        // HIGH from heating goes to NORMAL, then to COOLING.
        rep(3, 1'b0, 1'b1);
        chk("heat->normal state", 32'(state), 32'd0);
        chk("heat->normal drives", 32'({heaterOn, coolerOn}), 32'd0);
        rep(3, 1'b0, 1'b1);
        chk("cool state", 32'(state), 32'd2);
        chk("cool coolerOn", 32'(coolerOn), 32'd1);
        chk("cool count", 32'(abnormalEventCount), 32'd2);
        rep(3, 1'b0, 1'b0);
        chk("cool->normal", 32'(state), 32'd0);

        // Broken run does not confirm.
        rep(2, 1'b1, 1'b0);
        rep(1, 1'b0, 1'b0);
        rep(2, 1'b1, 1'b0);
        chk("broken run state", 32'(state), 32'd0);
        chk("broken run heater", 32'(heaterOn), 32'd0);

        // BOTH with idle gaps between samples -> FAULT.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            if (i < 2) for (int j = 0; j < 5; j++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("fault state", 32'(state), 32'd3);
        chk("fault alarm", 32'(alarm), 32'd1);
        chk("fault count", 32'(abnormalEventCount), 32'd3);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'(i % 2), 1'(i / 2 % 2), 1'b0);
        chk("fault sticky", 32'(state), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear state", 32'(state), 32'd0);
        chk("clear alarm", 32'(alarm), 32'd0);

        // clearFault outside FAULT does not disturb a run.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear ignored", 32'(state), 32'd1);
        chk("count before rst", 32'(abnormalEventCount), 32'd4);
        rep(3, 1'b0, 1'b0);

        // Reset aborts a partial run.
        rep(2, 1'b1, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst mid-run outputs", 32'({heaterOn, coolerOn, alarm, state}), 32'd0);
        chk("rst mid-run count", 32'(abnormalEventCount), 32'd0);
        rst = 1'b1;
        rep(1, 1'b1, 1'b0);
        chk("post-rst single LOW", 32'(state), 32'd0);
        rep(1, 1'b0, 1'b0);

        // Five entries saturate the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            rep(3, 1'(i % 2 == 0), 1'(i % 2 == 1));
            rep(3, 1'b0, 1'b0);
        end
        chk("sat count", 32'(sEventCount), 32'd3);
        chk("wide count", 32'(abnormalEventCount), 32'd5);
        rep(3, 1'b1, 1'b0);
        chk("sat hold", 32'(sEventCount), 32'd3);
        chk("wide count 6", 32'(abnormalEventCount), 32'd6);

        // Randomized traffic against the model.
        begin
            logic lo, hi;
            lo = 1'b0; hi = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(3) == 0) begin
                    lo = 1'($urandom_range(1));
                    hi = 1'($urandom_range(1));
                end
                rst = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
                drive(1'($urandom_range(2) != 0), lo, hi, 1'($urandom_range(9) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
